// File: rtl/key_event_ctrl.sv
// key_event_ctrl: sample-tick divider, hysteresis debounce, per-key press classifier
// and 2-entry event FIFO for the two-button front panel.  Rev 1.0
`default_nettype none

module key_event_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int DEB_CNT      = 12,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST_N,
  input  logic [1:0] Key_In,
  input  logic       Evt_Ready,
  input  logic       Ovf_Clr,
  output logic       Evt_Valid,
  output logic       Evt_Key,
  output logic [1:0] Evt_Type,
  output logic       Evt_Ovf,
  output logic [1:0] Key_Level
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] T_SHORT  = 2'b00;
  localparam logic [1:0] T_LONG   = 2'b01;
  localparam logic [1:0] T_REPEAT = 2'b10;
  localparam logic [1:0] T_COMBO  = 2'b11;

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, SUPPRESS} state_t;
  typedef struct packed {
    logic       key;
    logic [1:0] typ;
  } evt_t;

  logic [1:0]         sync1, sync2;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [DEB_CNT-1:0] sh      [2];
  logic [DEB_CNT-1:0] sh_next [2];
  state_t             state   [2];
  state_t             state_n [2];
  logic [15:0]        hold_cnt [2];
  logic [15:0]        hold_n   [2];
  logic [15:0]        rep_cnt  [2];
  logic [15:0]        rep_n    [2];
  logic               emit     [2];
  logic [1:0]         etype    [2];
  logic               combo;
  logic               push     [2];
  evt_t               pevt     [2];
  evt_t               fifo     [2];
  evt_t               fifo_n   [2];
  logic [1:0]         cnt, cnt_n;
  logic               drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sh_next[k] = {sh[k][DEB_CNT-2:0], sync2[k]};
    end
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      tick_cnt  <= '0;
      Key_Level <= 2'b00;
      for (int k = 0; k < 2; k++) sh[k] <= '0;
    end else begin
      sync1    <= Key_In;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        // Level only moves on a full run of equal samples; mixed history holds it.
        for (int k = 0; k < 2; k++) begin
          sh[k] <= sh_next[k];
          if (&sh_next[k])       Key_Level[k] <= 1'b1;
          else if (~|sh_next[k]) Key_Level[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      for (int k = 0; k < 2; k++) begin
        state[k]    <= IDLE;
        hold_cnt[k] <= '0;
        rep_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state[k]    <= state_n[k];
        hold_cnt[k] <= hold_n[k];
        rep_cnt[k]  <= rep_n[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_n[k] = state[k];
      hold_n[k]  = hold_cnt[k];
      rep_n[k]   = rep_cnt[k];
      emit[k]    = 1'b0;
      etype[k]   = T_SHORT;
      if (tick) begin
        case (state[k])
          IDLE: begin
            if (Key_Level[k]) begin
              state_n[k] = PRESS;
              hold_n[k]  = '0;
            end
          end
          PRESS: begin
            hold_n[k] = sat_inc(hold_cnt[k]);
            if (!Key_Level[k]) begin
              state_n[k] = IDLE;
              emit[k]    = 1'b1;
              etype[k]   = T_SHORT;
            end else if (hold_n[k] == 16'(LONG_TICKS)) begin
              state_n[k] = HOLD;
              rep_n[k]   = '0;
              emit[k]    = 1'b1;
              etype[k]   = T_LONG;
            end
          end
          HOLD: begin
            if (!Key_Level[k]) begin
              state_n[k] = IDLE;
            end else begin
              rep_n[k] = sat_inc(rep_cnt[k]);
              if (rep_n[k] == 16'(REPEAT_TICKS)) begin
                rep_n[k] = '0;
                emit[k]  = 1'b1;
                etype[k] = T_REPEAT;
              end
            end
          end
          default: begin
            if (!Key_Level[k]) state_n[k] = IDLE;
          end
        endcase
      end
    end
    // A combo overrides whatever either key would have emitted on this tick.
    combo = tick && (state[0] == PRESS) && (state[1] == PRESS) && (Key_Level == 2'b11);
    if (combo) begin
      state_n[0] = SUPPRESS;
      state_n[1] = SUPPRESS;
    end
    push[0] = combo || emit[0];
    pevt[0] = combo ? evt_t'({1'b0, T_COMBO}) : evt_t'({1'b0, etype[0]});
    push[1] = !combo && emit[1];
    pevt[1] = evt_t'({1'b1, etype[1]});
  end

  // Pop is applied before the pushes so a full FIFO being drained does not drop.
  always_comb begin
    fifo_n[0] = fifo[0];
    fifo_n[1] = fifo[1];
    cnt_n     = cnt;
    drop      = 1'b0;
    if (Evt_Valid && Evt_Ready) begin
      fifo_n[0] = fifo[1];
      fifo_n[1] = '0;
      cnt_n     = cnt - 2'd1;
    end
    for (int j = 0; j < 2; j++) begin
      if (push[j]) begin
        if (cnt_n == 2'd2) begin
          drop = 1'b1;
        end else begin
          if (cnt_n == 2'd0) fifo_n[0] = pevt[j];
          else               fifo_n[1] = pevt[j];
          cnt_n = cnt_n + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      cnt     <= 2'd0;
      Evt_Ovf <= 1'b0;
    end else begin
      fifo[0] <= fifo_n[0];
      fifo[1] <= fifo_n[1];
      cnt     <= cnt_n;
      if (drop)         Evt_Ovf <= 1'b1;
      else if (Ovf_Clr) Evt_Ovf <= 1'b0;
    end
  end

  assign Evt_Valid = (cnt != 2'd0);
  assign Evt_Key   = fifo[0].key;
  assign Evt_Type  = fifo[0].typ;

endmodule

`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed self-checking bench for key_event_ctrl with small timing parameters.
`default_nettype none

module tb_key_event_ctrl;

  logic       Sys_CLK;
  logic       Sys_RST_N;
  logic [1:0] Key_In;
  logic       Evt_Ready;
  logic       Ovf_Clr;
  logic       Evt_Valid;
  logic       Evt_Key;
  logic [1:0] Evt_Type;
  logic       Evt_Ovf;
  logic [1:0] Key_Level;

  key_event_ctrl #(
    .TICK_DIV(4), .DEB_CNT(4), .LONG_TICKS(8), .REPEAT_TICKS(3)
  ) dut (
    .Sys_CLK(Sys_CLK), .Sys_RST_N(Sys_RST_N), .Key_In(Key_In),
    .Evt_Ready(Evt_Ready), .Ovf_Clr(Ovf_Clr), .Evt_Valid(Evt_Valid),
    .Evt_Key(Evt_Key), .Evt_Type(Evt_Type), .Evt_Ovf(Evt_Ovf), .Key_Level(Key_Level)
  );

  initial Sys_CLK = 1'b0;
  always #5 Sys_CLK = ~Sys_CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Accepted-event log and level statistics, sampled on the falling edge.
  logic       ev_key  [$];
  logic [1:0] ev_type [$];
  int         ev_cyc  [$];
  int         cyc = 0;
  int         valid_cycles = 0;
  int         lvl0_cycles = 0;
  int         lvl0_rise_cyc = 0;
  logic       lvl0_prev = 1'b0;
  logic       lvl1_seen = 1'b0;

  always @(negedge Sys_CLK) begin
    cyc++;
    if (Evt_Valid && Evt_Ready) begin
      ev_key.push_back(Evt_Key);
      ev_type.push_back(Evt_Type);
      ev_cyc.push_back(cyc);
    end
    if (Evt_Valid === 1'b1) valid_cycles++;
    if (Key_Level[0] === 1'b1) lvl0_cycles++;
    if (Key_Level[1] === 1'b1) lvl1_seen = 1'b1;
    if (Key_Level[0] === 1'b1 && !lvl0_prev) lvl0_rise_cyc = cyc;
    lvl0_prev = Key_Level[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev_at(input int idx);
    if (idx < ev_key.size()) return {28'd0, 1'b0, ev_key[idx], ev_type[idx]};
    return 32'hDEAD;
  endfunction

  function automatic int cyc_at(input int idx);
    if (idx < ev_cyc.size()) return ev_cyc[idx];
    return -1000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Sys_CLK);
    #1;
  endtask

  task automatic tk(input int n);
    step(4 * n);
  endtask

  int b_ev, b_lv, b_v, n;

  initial begin
    Sys_RST_N = 1'b0;
    Key_In    = 2'b00;
    Evt_Ready = 1'b0;
    Ovf_Clr   = 1'b0;
    step(3);
    chk("rst_valid", Evt_Valid, 1'b0);
    chk("rst_key",   Evt_Key,   1'b0);
    chk("rst_type",  Evt_Type,  2'b00);
    chk("rst_ovf",   Evt_Ovf,   1'b0);
    chk("rst_level", Key_Level, 2'b00);
    Sys_RST_N = 1'b1;
    Evt_Ready = 1'b1;
    step(5);

    // Short press: 5 sampled ticks keep the level high for 5 ticks.
    b_ev = ev_key.size(); b_lv = lvl0_cycles; b_v = valid_cycles;
    Key_In[0] = 1'b1; tk(5); Key_In[0] = 1'b0; tk(15);
    chk("short_count", ev_key.size() - b_ev, 1);
    chk("short_evt",   ev_at(b_ev), {1'b0, 2'b00});
    chk("short_level_cycles", lvl0_cycles - b_lv, 20);
    chk("short_visible_cycles", valid_cycles - b_v, 1);

    // Bounce on key1: two samples per phase never fill the debounce window.
    b_ev = ev_key.size();
    for (int i = 0; i < 10; i++) begin
      Key_In[1] = 1'b1; tk(2); Key_In[1] = 1'b0; tk(2);
    end
    tk(10);
    chk("bounce_no_event", ev_key.size() - b_ev, 0);
    chk("bounce_level1",   lvl1_seen, 1'b0);

    // Long hold: LONG 9 ticks after the level rises, REPEAT every 3 ticks, silent release.
    b_ev = ev_key.size();
    Key_In[0] = 1'b1; tk(20); Key_In[0] = 1'b0; tk(12);
    chk("hold_count", ev_key.size() - b_ev, 4);
    chk("hold_long",  ev_at(b_ev),     {1'b0, 2'b01});
    chk("hold_rep1",  ev_at(b_ev + 1), {1'b0, 2'b10});
    chk("hold_rep2",  ev_at(b_ev + 2), {1'b0, 2'b10});
    chk("hold_rep3",  ev_at(b_ev + 3), {1'b0, 2'b10});
    chk("long_latency", cyc_at(b_ev) - lvl0_rise_cyc, 36);
    chk("rep1_gap", cyc_at(b_ev + 1) - cyc_at(b_ev), 12);
    chk("rep2_gap", cyc_at(b_ev + 2) - cyc_at(b_ev + 1), 12);

    // Combo: both keys together, held past LONG_TICKS.
    b_ev = ev_key.size();
    Key_In = 2'b11; tk(15); Key_In = 2'b00; tk(12);
    chk("combo_count", ev_key.size() - b_ev, 1);
    chk("combo_evt",   ev_at(b_ev), {1'b0, 2'b11});

    // Overflow: three shorts with the consumer stalled.
    Evt_Ready = 1'b0;
    Key_In[1] = 1'b1; tk(5); Key_In[1] = 1'b0; tk(12);
    Key_In[0] = 1'b1; tk(5); Key_In[0] = 1'b0; tk(12);
    chk("ovf_before_drop", Evt_Ovf, 1'b0);
    Key_In[1] = 1'b1; tk(5); Key_In[1] = 1'b0; tk(12);
    chk("ovf_valid", Evt_Valid, 1'b1);
    chk("ovf_head",  {Evt_Key, Evt_Type}, {1'b1, 2'b00});
    chk("ovf_set",   Evt_Ovf, 1'b1);
    Ovf_Clr = 1'b1; step(1); Ovf_Clr = 1'b0;
    chk("ovf_clear", Evt_Ovf, 1'b0);
    b_ev = ev_key.size();
    Evt_Ready = 1'b1; step(2);
    chk("pop_count",  ev_key.size() - b_ev, 2);
    chk("pop_first",  ev_at(b_ev),     {1'b1, 2'b00});
    chk("pop_second", ev_at(b_ev + 1), {1'b0, 2'b00});
    chk("pop_empty",  Evt_Valid, 1'b0);

    // Reset during PRESS with Hold_Cnt=5, key kept down through reset.
    b_ev = ev_key.size();
    Key_In[0] = 1'b1;
    for (int i = 0; i < 100 && Key_Level[0] !== 1'b1; i++) @(negedge Sys_CLK);
    chk("pre_reset_level", Key_Level[0], 1'b1);
    repeat (25) @(posedge Sys_CLK);
    #1 Sys_RST_N = 1'b0;
    #1;
    chk("mid_reset_level", Key_Level, 2'b00);
    chk("mid_reset_outs",  {Evt_Valid, Evt_Key, Evt_Type, Evt_Ovf}, 5'b00000);
    step(3);
    Sys_RST_N = 1'b1;
    n = 0;
    while (n < 100 && Key_Level[0] !== 1'b1) begin
      step(1);
      n++;
    end
    chk("post_reset_rise_edges", n, 16);
    tk(3); Key_In[0] = 1'b0; tk(12);
    chk("post_reset_count", ev_key.size() - b_ev, 1);
    chk("post_reset_short", ev_at(b_ev), {1'b0, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
